// File: rtl/pll_lock_monitor.sv
// Lock/frequency monitor for a PLL output clock: counts CLK cycles per REF period and
// qualifies lock against an expected ratio with hysteresis.
module pll_lock_monitor #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned EXP_RATIO    = 8,
  parameter int unsigned TOL          = 1,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             REF,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lock_lost,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StArm     = 2'b01,
    StMeasure = 2'b10,
    StLocked  = 2'b11
  } state_e;

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W:0]   ExpWide = (CNT_W + 1)'(EXP_RATIO);
  localparam logic [CNT_W:0]   TolWide = (CNT_W + 1)'(TOL);
  localparam logic [GoodW-1:0] GoodTgt = GoodW'(LOCK_COUNT);
  localparam logic [BadW-1:0]  BadTgt  = BadW'(UNLOCK_COUNT);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ref_prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GoodW-1:0]       good_q, good_d, good_inc;
  logic [BadW-1:0]        bad_q, bad_d, bad_inc;
  logic                   locked_q, locked_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   pv_q, pv_d;
  logic                   lost_q, lost_d;

  logic             ref_rise;
  logic [CNT_W:0]   cnt_wide, diff;
  logic             match;

  // REF synchronizer plus one extra flop for rising-edge detection.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      ref_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], REF};
      ref_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ref_rise = sync_q[SYNC_STAGES-1] & ~ref_prev_q;

  // Saturated count never matches, so a lost REF can't look like a valid period.
  assign cnt_wide = {1'b0, cnt_q};
  assign diff     = (cnt_wide >= ExpWide) ? (cnt_wide - ExpWide) : (ExpWide - cnt_wide);
  assign match    = (cnt_q != CntMax) && (diff <= TolWide);
  assign good_inc = good_q + GoodW'(1);
  assign bad_inc  = bad_q + BadW'(1);

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      period_q <= '0;
      pv_q     <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      lost_q   <= lost_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    bad_d    = bad_q;
    locked_d = locked_q;
    period_d = period_q;
    pv_d     = 1'b0;
    lost_d   = 1'b0;

    if (!en) begin
      state_d  = StIdle;
      cnt_d    = '0;
      good_d   = '0;
      bad_d    = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d    = '0;
          good_d   = '0;
          bad_d    = '0;
          locked_d = 1'b0;
          state_d  = StArm;
        end
        StArm: begin
          good_d   = '0;
          bad_d    = '0;
          locked_d = 1'b0;
          if (ref_rise) begin
            cnt_d   = CNT_W'(1);
            state_d = StMeasure;
          end else begin
            cnt_d = '0;
          end
        end
        StMeasure, StLocked: begin
          if (ref_rise) begin
            cnt_d    = CNT_W'(1);
            pv_d     = 1'b1;
            period_d = cnt_q;
            if (state_q == StMeasure) begin
              if (match) begin
                good_d = good_inc;
                if (good_inc == GoodTgt) begin
                  state_d  = StLocked;
                  locked_d = 1'b1;
                  bad_d    = '0;
                end
              end else begin
                good_d = '0;
              end
            end else if (match) begin
              bad_d = '0;
            end else if (bad_inc == BadTgt) begin
              state_d  = StMeasure;
              locked_d = 1'b0;
              good_d   = '0;
              bad_d    = '0;
              lost_d   = 1'b1;
            end else begin
              bad_d = bad_inc;
            end
          end else if (cnt_q == CntMax) begin
            // REF has stopped: re-arm and discard the next partial period.
            state_d  = StArm;
            cnt_d    = '0;
            good_d   = '0;
            bad_d    = '0;
            locked_d = 1'b0;
            lost_d   = (state_q == StLocked);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic
  always_comb begin
    period       = period_q;
    period_valid = pv_q;
    locked       = locked_q;
    lock_lost    = lost_q;
    state        = state_q;
  end

endmodule
